branch_predictor: RTL and testbench

//  Dynamic branch direction predictor for the fetch/decode front end; replaces static always-taken.

---
 rtl/branch_predictor.sv | 158 +++++++++++++++
 tb/tb_branch_predictor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch direction predictor for the fetch/decode front end.
//   A table of saturating counters is indexed either by the fetch PC
//   (bimodal, MODE=0) or by the PC xor'ed with a global history register
//   (gshare, MODE=1). A lookup presented in one cycle is answered in the
//   next cycle, lined up with the instruction memory read data. Resolved
//   branches from decode train the counters and shift the history.
//   After reset the table is walked once, one entry per cycle, to the
//   weakly-taken value; meanwhile predictions fall back to static taken.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   lookup_valid          lookup request this cycle
//   lookup_pc[31:0]       fetch address
//   hold                  stall: pred_* outputs frozen, lookup ignored
//   pred_valid            pred_* valid, one cycle after an accepted lookup
//   pred_taken            predicted direction
//   pred_idx[IDX_W-1:0]   table index used; comes back later as upd_idx
//   upd_valid             resolved conditional branch this cycle
//   upd_idx[IDX_W-1:0]    table index of that branch
//   upd_taken             actual direction
//   upd_mispred           the prediction for that branch was wrong
//   ready                 table initialised, predictions are dynamic
//   perf_branches[31:0]   upd_valid cycles since reset (wrapping)
//   perf_mispred[31:0]    upd_valid && upd_mispred cycles since reset
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter  int ENTRIES = 256,
  parameter  int CTR_W   = 2,
  parameter  int GHR_W   = 8,
  parameter  int MODE    = 1,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  input  logic             hold,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic             ready,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispred
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  state_t             state;
  logic [IDX_W-1:0]   init_ptr;
  logic [GHR_W-1:0]   ghr;
  logic [CTR_W-1:0]   ctr_table [ENTRIES];

  logic [IDX_W-1:0]   lookup_idx;
  logic [CTR_W-1:0]   lookup_ctr;
  logic [CTR_W-1:0]   upd_ctr_old;
  logic [CTR_W-1:0]   upd_ctr_new;
  logic               upd_write;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [CTR_W-1:0]   wr_data;

  // PC bits below the word offset and above the index never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};

  // Index uses the history as it stood before any update landing this cycle.
  assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ((MODE == 1) ? IDX_W'(ghr) : '0);

  // Training only happens once the table holds defined values.
  assign upd_write   = (state == RUN) && upd_valid;
  assign upd_ctr_old = ctr_table[upd_idx];

  // Saturating step; the counter never wraps past either end.
  always_comb begin
    upd_ctr_new = upd_ctr_old;
    if (upd_taken) begin
      if (upd_ctr_old != CTR_MAX) upd_ctr_new = upd_ctr_old + 1'b1;
    end else begin
      if (upd_ctr_old != '0) upd_ctr_new = upd_ctr_old - 1'b1;
    end
  end

  // A lookup hitting the entry being trained this cycle sees the new value.
  assign lookup_ctr = (upd_write && (upd_idx == lookup_idx)) ? upd_ctr_new
                                                             : ctr_table[lookup_idx];

  // Single write port shared by the init walk and training.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = upd_idx;
    wr_data = upd_ctr_new;
    if (!rst) begin
      if (state == INIT) begin
        wr_en   = 1'b1;
        wr_addr = init_ptr;
        wr_data = CTR_WEAK;
      end else if (upd_valid) begin
        wr_en = 1'b1;
      end
    end
  end

  // Counter storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) ctr_table[wr_addr] <= wr_data;
  end

  // Control FSM, history, prediction outputs and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      init_ptr      <= '0;
      ghr           <= '0;
      pred_valid    <= 1'b0;
      pred_taken    <= 1'b1;
      pred_idx      <= '0;
      ready         <= 1'b0;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == IDX_W'(ENTRIES - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (upd_valid) ghr <= (ghr << 1) | GHR_W'(upd_taken);
        end
        default: state <= INIT;
      endcase

      // Until the table is initialised, fall back to static taken.
      if (!hold) begin
        pred_valid <= lookup_valid;
        if (lookup_valid) begin
          pred_taken <= (state == RUN) ? lookup_ctr[CTR_W-1] : 1'b1;
          pred_idx   <= lookup_idx;
        end
      end

      if (upd_valid) perf_branches <= perf_branches + 32'd1;
      if (upd_valid && upd_mispred) perf_mispred <= perf_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Drives a gshare instance and a bimodal instance with the same stimulus
//   and compares both against a table-level reference model: an array of
//   integer counters, an integer history, and a countdown for the init walk.
//   Directed vectors and short hand-written sequences cover the corner
//   cases; a randomized phase and a mid-run reset follow.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        hold;
  logic        upd_valid;
  logic [7:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispred;

  logic        pv_g, pt_g, ready_g;
  logic [7:0]  pidx_g;
  logic [31:0] pb_g, pm_g;
  logic        pv_b, pt_b, ready_b;
  logic [7:0]  pidx_b;
  logic [31:0] pb_b, pm_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       m_ctr [256];
  int       m_ghr;
  int       m_init_left;
  bit       m_ready;
  bit [31:0] m_pb, m_pm;
  bit       m_pv [2];
  bit       m_pt [2];
  int       m_pidx [2];

  branch_predictor #(.ENTRIES(256), .CTR_W(2), .GHR_W(8), .MODE(1)) dut_g (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .hold(hold), .pred_valid(pv_g), .pred_taken(pt_g), .pred_idx(pidx_g),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .ready(ready_g), .perf_branches(pb_g),
    .perf_mispred(pm_g)
  );

  branch_predictor #(.ENTRIES(256), .CTR_W(2), .GHR_W(8), .MODE(0)) dut_b (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .hold(hold), .pred_valid(pv_b), .pred_taken(pt_b), .pred_idx(pidx_b),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .ready(ready_b), .perf_branches(pb_b),
    .perf_mispred(pm_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         lv;
    logic [31:0] pc;
    bit         uv;
    logic [7:0] ui;
    bit         ut;
    bit         exp_pv;
    bit         exp_pt;
    logic [7:0] exp_idx;
  } vec_t;

  vec_t vecs [12];

  function automatic int sat_next(int c, bit t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance the reference model by one clock with the current inputs.
  task automatic model_step();
    bit in_run;
    int idx, c;
    if (rst) begin
      m_init_left = 256;
      m_ready = 0;
      m_ghr = 0;
      m_pb = 0;
      m_pm = 0;
      for (int m = 0; m < 2; m++) begin
        m_pv[m] = 0; m_pt[m] = 1; m_pidx[m] = 0;
      end
    end else begin
      in_run = (m_init_left == 0);
      if (upd_valid) m_pb = m_pb + 1;
      if (upd_valid && upd_mispred) m_pm = m_pm + 1;
      for (int m = 0; m < 2; m++) begin
        if (!hold) begin
          if (lookup_valid) begin
            idx = ((lookup_pc >> 2) & 255) ^ ((m == 1) ? m_ghr : 0);
            c = m_ctr[idx];
            if (in_run && upd_valid && int'(upd_idx) == idx) c = sat_next(c, upd_taken);
            m_pt[m] = in_run ? (c >= 2) : 1'b1;
            m_pv[m] = 1;
            m_pidx[m] = idx;
          end else begin
            m_pv[m] = 0;
          end
        end
      end
      if (in_run && upd_valid) begin
        m_ctr[upd_idx] = sat_next(m_ctr[upd_idx], upd_taken);
        m_ghr = ((m_ghr << 1) | int'(upd_taken)) & 255;
      end
      if (!in_run) begin
        m_ctr[256 - m_init_left] = 2;
        m_init_left--;
        if (m_init_left == 0) m_ready = 1;
      end
    end
  endtask

  task automatic model_check();
    checkOutput("ready_g", {31'd0, ready_g}, {31'd0, m_ready});
    checkOutput("ready_b", {31'd0, ready_b}, {31'd0, m_ready});
    checkOutput("perf_branches_g", pb_g, m_pb);
    checkOutput("perf_branches_b", pb_b, m_pb);
    checkOutput("perf_mispred_g", pm_g, m_pm);
    checkOutput("perf_mispred_b", pm_b, m_pm);
    checkOutput("pred_valid_g", {31'd0, pv_g}, {31'd0, m_pv[1]});
    checkOutput("pred_valid_b", {31'd0, pv_b}, {31'd0, m_pv[0]});
    if (m_pv[1]) begin
      checkOutput("pred_taken_g", {31'd0, pt_g}, {31'd0, m_pt[1]});
      checkOutput("pred_idx_g", {24'd0, pidx_g}, m_pidx[1]);
    end
    if (m_pv[0]) begin
      checkOutput("pred_taken_b", {31'd0, pt_b}, {31'd0, m_pt[0]});
      checkOutput("pred_idx_b", {24'd0, pidx_b}, m_pidx[0]);
    end
  endtask

  // One clock: model and DUT advance together, outputs sampled 1 after the edge.
  task automatic applyStimulus();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle_inputs();
    rst = 0; lookup_valid = 0; lookup_pc = 0; hold = 0;
    upd_valid = 0; upd_idx = 0; upd_taken = 0; upd_mispred = 0;
  endtask

  task automatic random_inputs(input bit allow_hold);
    int idx;
    idx = $urandom_range(0, 63);
    lookup_valid = ($urandom_range(0, 3) != 0);
    lookup_pc = ($urandom & 32'hFFFF_FC00) | (idx << 2) | $urandom_range(0, 3);
    hold = allow_hold && ($urandom_range(0, 7) == 0);
    upd_valid = $urandom_range(0, 1);
    case ($urandom_range(0, 3))
      0, 1: upd_idx = 8'(idx);
      2:    upd_idx = 8'(idx ^ m_ghr);
      default: upd_idx = 8'($urandom_range(0, 255));
    endcase
    upd_taken = $urandom_range(0, 1);
    upd_mispred = $urandom_range(0, 1);
  endtask

  // Waits out the init walk, returning the number of edges until ready.
  task automatic wait_ready(output int n);
    n = 0;
    while (ready_g !== 1'b1 && n < 300) begin
      random_inputs(1'b1);
      applyStimulus();
      n++;
    end
  endtask

  initial begin
    int n;
    bit [7:0] hist_bits;

    vecs[0]  = '{1'b0, 32'h40, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 32'h40, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 32'h40, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 32'h40, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 8'h10};
    vecs[4]  = '{1'b1, 32'h40, 1'b1, 8'd16, 1'b1, 1'b1, 1'b0, 8'h10};
    vecs[5]  = '{1'b1, 32'h40, 1'b1, 8'd16, 1'b1, 1'b1, 1'b1, 8'h10};
    vecs[6]  = '{1'b0, 32'h0C, 1'b1, 8'd3,  1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 32'h0C, 1'b1, 8'd3,  1'b1, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 32'h0C, 1'b1, 8'd3,  1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 32'h0C, 1'b1, 8'd3,  1'b1, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 32'h0C, 1'b1, 8'd3,  1'b1, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 32'h0C, 1'b1, 8'd3,  1'b0, 1'b1, 1'b1, 8'h03};

    for (int i = 0; i < 256; i++) m_ctr[i] = 0;

    // Reset and its output values
    idle_inputs();
    rst = 1;
    applyStimulus();
    checkOutput("reset_pred_taken", {31'd0, pt_g}, 32'd1);
    checkOutput("reset_pred_idx", {24'd0, pidx_g}, 32'd0);
    rst = 0;

    // Init walk: static taken, exact length
    wait_ready(n);
    checkOutput("init_length", n, 256);

    // Directed bimodal vectors from a freshly initialised table
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      lookup_valid = vecs[i].lv; lookup_pc = vecs[i].pc;
      upd_valid = vecs[i].uv; upd_idx = vecs[i].ui; upd_taken = vecs[i].ut;
      applyStimulus();
      checkOutput($sformatf("vec%0d_pred_valid", i), {31'd0, pv_b}, {31'd0, vecs[i].exp_pv});
      if (vecs[i].exp_pv) begin
        checkOutput($sformatf("vec%0d_pred_taken", i), {31'd0, pt_b}, {31'd0, vecs[i].exp_pt});
        checkOutput($sformatf("vec%0d_pred_idx", i), {24'd0, pidx_b}, {24'd0, vecs[i].exp_idx});
      end
    end

    // Build history 0b00000101 then compare gshare and bimodal indices
    hist_bits = 8'b00000101;
    for (int i = 7; i >= 0; i--) begin
      idle_inputs();
      upd_valid = 1; upd_idx = 8'd200; upd_taken = hist_bits[i];
      applyStimulus();
    end
    idle_inputs();
    lookup_valid = 1; lookup_pc = 32'h40;
    applyStimulus();
    checkOutput("gshare_idx", {24'd0, pidx_g}, 32'h15);
    checkOutput("bimodal_idx", {24'd0, pidx_b}, 32'h10);

    // Same-cycle lookup and training of idx 16 (counter 2 -> 1)
    idle_inputs();
    lookup_valid = 1; lookup_pc = 32'h40;
    upd_valid = 1; upd_idx = 8'd16; upd_taken = 0;
    applyStimulus();
    checkOutput("forward_taken", {31'd0, pt_b}, 32'd0);
    checkOutput("forward_idx", {24'd0, pidx_b}, 32'h10);

    // Hold for 3 cycles while other traffic is present
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      hold = 1; lookup_valid = 1; lookup_pc = 32'h0C;
      upd_valid = 1; upd_idx = 8'd16; upd_taken = 1;
      applyStimulus();
      checkOutput("hold_valid", {31'd0, pv_b}, 32'd1);
      checkOutput("hold_taken", {31'd0, pt_b}, 32'd0);
      checkOutput("hold_idx", {24'd0, pidx_b}, 32'h10);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      random_inputs(1'b1);
      applyStimulus();
    end

    // Mispredict counter wrap
    idle_inputs();
    @(negedge clk);
    force dut_g.perf_mispred = 32'hFFFF_FFFF;
    force dut_b.perf_mispred = 32'hFFFF_FFFF;
    #1;
    release dut_g.perf_mispred;
    release dut_b.perf_mispred;
    m_pm = 32'hFFFF_FFFF;
    upd_valid = 1; upd_mispred = 1; upd_idx = 8'd7; upd_taken = 1;
    applyStimulus();
    checkOutput("perf_mispred_wrap", pm_g, 32'd0);

    for (int i = 0; i < 200; i++) begin
      random_inputs(1'b1);
      applyStimulus();
    end

    // Reset in the middle of RUN
    random_inputs(1'b0);
    rst = 1;
    applyStimulus();
    checkOutput("midrst_ready", {31'd0, ready_g}, 32'd0);
    checkOutput("midrst_perf_branches", pb_g, 32'd0);
    checkOutput("midrst_perf_mispred", pm_g, 32'd0);
    checkOutput("midrst_pred_valid", {31'd0, pv_g}, 32'd0);
    checkOutput("midrst_pred_taken", {31'd0, pt_g}, 32'd1);
    rst = 0;
    wait_ready(n);
    checkOutput("reinit_length", n, 256);

    for (int i = 0; i < 300; i++) begin
      random_inputs(1'b1);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
